mem_dumper: RTL
===============

MEM_DUMPER -- requirements
Module: mem_dumper

Interface
REQ-001 Parameter: DW, default 16, sets the width of the data and address paths.
REQ-002 Port: clk, input, 1 bit, single system clock; all state changes on its rising edge.
REQ-003 Port: reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 Port: start, input, 1 bit, one-cycle request to begin a dump.
REQ-005 Port: base, input, DW bits, first memory address to read; sampled at accepted start.
REQ-006 Port: count, input, DW bits, number of words to read; sampled at accepted start.
REQ-007 Port: maxmem, input, DW bits, highest valid memory address.
REQ-008 Port: memout, input, DW bits, memory read data; a combinational function of marval.
REQ-009 Port: marval, output, DW bits, memory address driven while busreq is high.
REQ-010 Port: mrw, output, 1 bit, memory write enable; held at 0 at all times.
REQ-011 Port: busreq, output, 1 bit, high while the block owns the memory address bus.
REQ-012 Port: dout, output, DW bits, captured memory word.
REQ-013 Port: dvalid, output, 1 bit, dout holds a word not yet accepted by the sink.
REQ-014 Port: dready, input, 1 bit, sink accepts dout when dvalid and dready are both high at a clock edge.
REQ-015 Port: busy, output, 1 bit, high in every state except IDLE.
REQ-016 Port: done, output, 1 bit, one-cycle pulse at the end of every accepted dump.
REQ-017 Port: err, output, 1 bit, sticky range error; cleared by the next accepted start.

Function
REQ-018 FSM states: IDLE, ADDR, CAPT, HOLD, FIN; internal registers: addr (DW bits), remaining (DW bits).
REQ-019 IDLE: start=1 is accepted; addr<=base, remaining<=count, err<=0.
REQ-020 On an accepted start: count=0 goes to FIN; base>maxmem sets err=1 and goes to FIN; otherwise goes to ADDR.
REQ-021 start while busy=1 is ignored, with no effect on any register.
REQ-022 ADDR: busreq=1, marval=addr; next state CAPT. This is one settle cycle.
REQ-023 CAPT: busreq=1, marval=addr; at the edge, dout<=memout, dvalid<=1; next state HOLD.
REQ-024 HOLD: busreq=0, marval=0; dout and dvalid hold until handshake.
REQ-025 HOLD handshake with remaining=1: dvalid<=0, remaining<=0; next state FIN.
REQ-026 HOLD handshake with remaining>1 and addr+1 within range: dvalid<=0, remaining decrements, addr increments; next state ADDR.
REQ-027 Range check after increment: addr+1>maxmem, or addr=all-ones (wrap to 0), sets err<=1; next state FIN; the word is not read.
REQ-028 FIN: done=1 for exactly one cycle, busreq=0; next state IDLE.
REQ-029 Latency: first dvalid rises 3 edges after the start edge; minimum throughput is 1 word per 3 cycles with dready tied high.
REQ-030 dout changes only in CAPT; dvalid=1 only in HOLD.
REQ-031 Outside ADDR/CAPT: marval=0 and busreq=0, so an external arbiter can hand the bus back to the CPU.

Reset
REQ-032 reset=1 forces IDLE asynchronously, with no clock required.
REQ-033 Reset values: addr=0, remaining=0, marval=0, mrw=0, busreq=0, dout=0, dvalid=0, busy=0, done=0, err=0.
REQ-034 Reset mid-dump abandons the transfer; no done pulse is produced and any pending dvalid drops immediately.
REQ-035 The first start is accepted on the first rising edge after reset is deasserted.

Verification
REQ-036 Basic dump: memory preloaded mem[0..3] = B00C, EA00, B000, B000; start with base=0, count=4, maxmem=4095, dready=1. Required: dout sequence B00C, EA00, B000, B000; done pulses once; err=0.
REQ-037 Backpressure: same dump with dready low for 5 cycles on word 2. Required: dout=EA00 and dvalid=1 stable throughout; busreq=0 during the stall; no word lost or duplicated.
REQ-038 Range overrun: base=4094, count=4, maxmem=4095. Required: exactly 2 words delivered (mem[4094], mem[4095]); then err=1 and done pulses once.
REQ-039 Degenerate start: count=0 gives done 2 edges after start with no dvalid; base=5000, maxmem=4095 gives err=1 and done with no busreq.
REQ-040 Reset and ignored start: reset asserted mid-HOLD drops dvalid and busy asynchronously, with no done; a start pulse while busy leaves base, count and sequence unchanged.

Source files
------------

// File: rtl/mem_dumper.sv
// Streams a block of memory words out through a valid/ready port.
// It owns the address bus only while it is fetching a word.
module mem_dumper #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] base,
  input  logic [DW-1:0] count,
  input  logic [DW-1:0] maxmem,
  input  logic [DW-1:0] memout,
  output logic [DW-1:0] marval,
  output logic          mrw,
  output logic          busreq,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  input  logic          dready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {IDLE, ADDR, CAPT, HOLD, FIN} state_t;

  state_t        state_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] remaining_q;
  logic [DW-1:0] marval_q;
  logic          busreq_q;
  logic [DW-1:0] dout_q;
  logic          dvalid_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic [DW-1:0] addrInc_d;
  logic          outOfRange_d;

  // The all-ones test catches the wrap to zero that the compare alone would miss.
  assign addrInc_d    = addr_q + DW'(1);
  assign outOfRange_d = (addr_q == '1) || (addrInc_d > maxmem);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      marval_q    <= '0;
      busreq_q    <= 1'b0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q      <= base;
            remaining_q <= count;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            if (count == '0) begin
              state_q <= FIN;
            end else if (base > maxmem) begin
              err_q   <= 1'b1;
              state_q <= FIN;
            end else begin
              busreq_q <= 1'b1;
              marval_q <= base;
              state_q  <= ADDR;
            end
          end
        end
        ADDR: begin
          state_q <= CAPT;
        end
        CAPT: begin
          dout_q   <= memout;
          dvalid_q <= 1'b1;
          busreq_q <= 1'b0;
          marval_q <= '0;
          state_q  <= HOLD;
        end
        HOLD: begin
          if (dvalid_q && dready) begin
            dvalid_q <= 1'b0;
            if (remaining_q == DW'(1)) begin
              remaining_q <= '0;
              state_q     <= FIN;
            end else if (outOfRange_d) begin
              err_q   <= 1'b1;
              state_q <= FIN;
            end else begin
              remaining_q <= remaining_q - DW'(1);
              addr_q      <= addrInc_d;
              marval_q    <= addrInc_d;
              busreq_q    <= 1'b1;
              state_q     <= ADDR;
            end
          end
        end
        FIN: begin
          // done is registered here, so it is seen in the cycle after FIN.
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busreq_q <= 1'b0;
          marval_q <= '0;
          dvalid_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign marval = marval_q;
  assign mrw    = 1'b0;
  assign busreq = busreq_q;
  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule
